stopwatch_count_ctrl: RTL and testbench
=======================================

Name: stopwatch_count_ctrl

Overview:
- Produces the 14-bit decimal display value (0..9999) consumed by the FND display controller's `count` input.
- Divides the system clock to a counting tick and advances an up/down modulo-10000 counter while running.
- A small run/stop/clear FSM is driven by edge-detected button levels.
- Sits between the button debouncers and the FND controller.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz. DIV = CLK_FREQ/TICK_HZ; DIV must be >= 2 (elaboration error otherwise).
- COUNT_MAX, 9999, highest count value; wrap modulus is COUNT_MAX+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_run_stop  in  1  debounced level, synchronous to clk; rising edge toggles run/stop
- btn_clear  in  1  debounced level, synchronous to clk; rising edge clears when stopped
- sw_mode  in  1  0 = count up, 1 = count down
- count  out  14  registered count value to the FND controller
- o_run  out  1  1 while in RUN
- o_tick  out  1  one-cycle pulse on each cycle where count advances

Behaviour:
- Single clock domain, clk only. Reset is synchronous and active-high, sampled on the rising edge of clk; no asynchronous reset path.
- Reset values:
  - count = 0, o_run = 0, o_tick = 0.
  - FSM = STOP, tick counter = 0.
  - Edge-detect registers load the current btn levels, so a button held through reset yields no edge.
- Edge detect: btn_x_re = btn_x & ~btn_x_d. Both registers always update, including during reset.
- FSM states and transitions (checked in priority order within each state):
  - STOP: clear_re -> CLEAR. Else run_stop_re -> RUN. Else stay. Clear wins when both edges occur in the same cycle.
  - RUN: run_stop_re -> STOP. clear_re is ignored.
  - CLEAR: count <= 0 and tick counter <= 0; go to STOP unconditionally next cycle. Edges arriving while in CLEAR are dropped.
- o_run = (state == RUN), registered with the state.
- Tick counter:
  - Width $clog2(DIV). Increments only in RUN; at DIV-1 it wraps to 0.
  - In STOP it holds, so pause/resume preserves phase.
- Count advance: on an edge where state == RUN and tick counter == DIV-1:
  - Up mode: count == COUNT_MAX -> 0, else count+1.
  - Down mode: count == 0 -> COUNT_MAX, else count-1.
  - o_tick = 1 in the same cycle count changes; 0 otherwise.
- Latency:
  - First advance lands DIV cycles after the edge where the FSM enters RUN from a cleared state.
  - Thereafter one advance every DIV cycles.
- sw_mode is sampled at each advance; a change mid-run takes effect at the next tick.
- If the run_stop edge leaving RUN coincides with tick counter == DIV-1, that advance still occurs (the FSM update and the count update share the edge).
- Arithmetic is done in 14 bits; count never exceeds COUNT_MAX.

Optional Feature:
- Macro: STOPWATCH_COUNT_DOWN_EN.
- Defined: sw_mode selects up/down as above.
- Undefined: sw_mode is ignored and the block always counts up; the down-count logic is not synthesized; the port remains for pin compatibility.

Decomposition:
- Shared package holds:
  - FSM state encoding (STOP = 2'd0, RUN = 2'd1, CLEAR = 2'd2)
  - COUNT_W = 14
  - default COUNT_MAX = 9999
- One sub-module: stopwatch_tick_gen.
  - Contents: the DIV counter.
  - Ports: clk, reset, enable, clear, tick.
  - Tick condition: tick is high when enable && cnt == DIV-1.
- The parent holds the edge detectors, the FSM and the count register.

Test Plan:
All scenarios use CLK_FREQ=100, TICK_HZ=10 (DIV=10).
1. Run and count: reset, then pulse btn_run_stop.
   - count = 1 ten cycles after RUN entry and 10 after 100 cycles; o_tick width exactly 1 cycle; o_run = 1.
2. Up wrap: run until count = 9999.
   - Next tick gives count = 0 with o_tick = 1.
3. Down wrap: cleared, sw_mode = 1, run.
   - With STOPWATCH_COUNT_DOWN_EN, first tick gives 9999 then 9998.
   - Without the macro, first tick gives 1.
4. Pause/resume phase: stop when count = 5 and tick counter = 3; wait 50 cycles.
   - count stays 5.
   - Resume: count = 6 exactly 7 cycles after RUN re-entry.
5. Clear rules:
   - btn_clear in RUN: no effect.
   - btn_clear in STOP at count = 42: CLEAR for one cycle, then count = 0 and STOP.
   - run_stop and clear edges in the same cycle in STOP: clear wins, o_run stays 0.
6. Reset mid-run at count = 17 with btn_run_stop held high:
   - count = 0 and o_run = 0 at the next edge.
   - After reset release, no spurious RUN until the button is released and pressed again.

Source files
------------

// File: rtl/stopwatch_count_ctrl_pkg.sv
// Shared types and constants for the stopwatch count controller.
package stopwatch_count_ctrl_pkg;

  localparam int unsigned COUNT_W           = 14;
  localparam int unsigned COUNT_MAX_DEFAULT = 9999;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Divide-by-DIV phase counter; tick flags the last phase while enabled.
module stopwatch_tick_gen
  import stopwatch_count_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next phase: clear dominates, hold when disabled so pause keeps phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_count_ctrl.sv
// Stopwatch count controller: button edges drive a run/stop/clear FSM and a
// modulo-(COUNT_MAX+1) display counter advanced at TICK_HZ.
// Build option: define STOPWATCH_COUNT_DOWN_EN to let sw_mode select down counting.
module stopwatch_count_ctrl
  import stopwatch_count_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned COUNT_MAX = COUNT_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run_stop,
  input  logic               btn_clear,
  input  logic               sw_mode,
  output logic [COUNT_W-1:0] count,
  output logic               o_run,
  output logic               o_tick
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(COUNT_MAX);

  if (DIV < 2) begin : g_div_check
    $error("stopwatch_count_ctrl: CLK_FREQ/TICK_HZ must be >= 2");
  end
  if (COUNT_MAX >= (1 << COUNT_W)) begin : g_max_check
    $error("stopwatch_count_ctrl: COUNT_MAX does not fit in COUNT_W bits");
  end

  logic               btn_run_stop_q;
  logic               btn_clear_q;
  logic               run_stop_re;
  logic               clear_re;
  sw_state_e          state_q;
  sw_state_e          state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               o_run_q;
  logic               o_run_d;
  logic               o_tick_q;
  logic               o_tick_d;
  logic               tick;

`ifndef STOPWATCH_COUNT_DOWN_EN
  logic unused_sw_mode;
  assign unused_sw_mode = sw_mode;
`endif

  // Button history; loads through reset so a held button gives no edge.
  always_ff @(posedge clk) begin
    btn_run_stop_q <= btn_run_stop;
    btn_clear_q    <= btn_clear;
  end

  assign run_stop_re = btn_run_stop & ~btn_run_stop_q;
  assign clear_re    = btn_clear & ~btn_clear_q;

  stopwatch_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RUN),
    .clear  (state_q == ST_CLEAR),
    .tick   (tick)
  );

  // Next state: clear beats run/stop in STOP; CLEAR lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (clear_re) begin
          state_d = ST_CLEAR;
        end else if (run_stop_re) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_stop_re) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // Next count and status outputs.
  always_comb begin
    count_d  = count_q;
    o_run_d  = (state_d == ST_RUN);
    o_tick_d = tick;
    if (state_q == ST_CLEAR) begin
      count_d = '0;
    end else if (tick) begin
`ifdef STOPWATCH_COUNT_DOWN_EN
      if (sw_mode) begin
        count_d = (count_q == '0) ? MAX_C : count_q - COUNT_W'(1);
      end else begin
        count_d = (count_q == MAX_C) ? '0 : count_q + COUNT_W'(1);
      end
`else
      count_d = (count_q == MAX_C) ? '0 : count_q + COUNT_W'(1);
`endif
    end
  end

  // State, count and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_STOP;
      count_q  <= '0;
      o_run_q  <= 1'b0;
      o_tick_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      o_run_q  <= o_run_d;
      o_tick_q <= o_tick_d;
    end
  end

  assign count  = count_q;
  assign o_run  = o_run_q;
  assign o_tick = o_tick_q;

endmodule

// File: tb/tb_stopwatch_count_ctrl.sv
// Self-checking bench for stopwatch_count_ctrl (DIV=10 main instance, DIV=2
// instance for the full up-wrap); honours STOPWATCH_COUNT_DOWN_EN.
module tb_stopwatch_count_ctrl;

  localparam int unsigned DIV  = 10;
  localparam int unsigned CMAX = 9999;

  typedef struct packed {
    logic [13:0] cnt;
    logic        run;
    logic        tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run_stop;
  logic        btn_clear;
  logic        sw_mode;
  logic [13:0] count;
  logic        o_run;
  logic        o_tick;

  logic        f_btn;
  logic [13:0] f_count;
  logic        f_run;
  logic        f_tick;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t sb_q[$];
  exp_t sb_e;

  // reference model state
  int unsigned m_state = 0;
  int unsigned m_tc    = 0;
  int unsigned m_cnt   = 0;
  bit          m_tick  = 0;
  bit          m_rs_prev = 0;
  bit          m_cl_prev = 0;
  bit          m_rs_re, m_cl_re, m_adv;

  always #5 clk = ~clk;

  stopwatch_count_ctrl #(
    .CLK_FREQ (100),
    .TICK_HZ  (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (btn_run_stop),
    .btn_clear    (btn_clear),
    .sw_mode      (sw_mode),
    .count        (count),
    .o_run        (o_run),
    .o_tick       (o_tick)
  );

  stopwatch_count_ctrl #(
    .CLK_FREQ (100),
    .TICK_HZ  (50)
  ) dut_fast (
    .clk          (clk),
    .reset        (reset),
    .btn_run_stop (f_btn),
    .btn_clear    (1'b0),
    .sw_mode      (1'b0),
    .count        (f_count),
    .o_run        (f_run),
    .o_tick       (f_tick)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle model of the main instance; pushes the expected post-edge outputs.
  always @(posedge clk) begin
    m_rs_re = btn_run_stop && !m_rs_prev;
    m_cl_re = btn_clear && !m_cl_prev;
    if (reset) begin
      m_state = 0; m_tc = 0; m_cnt = 0; m_tick = 0;
    end else begin
      m_adv  = (m_state == 1) && (m_tc == DIV - 1);
      m_tick = m_adv;
      if (m_adv) begin
`ifdef STOPWATCH_COUNT_DOWN_EN
        if (sw_mode) m_cnt = (m_cnt == 0) ? CMAX : m_cnt - 1;
        else         m_cnt = (m_cnt == CMAX) ? 0 : m_cnt + 1;
`else
        m_cnt = (m_cnt == CMAX) ? 0 : m_cnt + 1;
`endif
      end
      case (m_state)
        0: if (m_cl_re) m_state = 2; else if (m_rs_re) m_state = 1;
        1: begin
          m_tc = (m_tc == DIV - 1) ? 0 : m_tc + 1;
          if (m_rs_re) m_state = 0;
        end
        default: begin m_cnt = 0; m_tc = 0; m_state = 0; end
      endcase
    end
    m_rs_prev = btn_run_stop;
    m_cl_prev = btn_clear;
    sb_q.push_back('{cnt: 14'(m_cnt), run: (m_state == 1), tick: m_tick});
  end

  // Scoreboard: compare DUT outputs mid-cycle against the model queue.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      chk("sb_count", count, sb_e.cnt);
      chk("sb_run", o_run, sb_e.run);
      chk("sb_tick", o_tick, sb_e.tick);
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_run();
    btn_run_stop = 1'b1;
    @(negedge clk);
    btn_run_stop = 1'b0;
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
  endtask

  task automatic wait_count(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while (count != 14'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count", count, target);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1; btn_run_stop = 1'b0; btn_clear = 1'b0; sw_mode = 1'b0; f_btn = 1'b0;
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_run", o_run, 0);
    chk("rst_tick", o_tick, 0);
    reset = 1'b0;
    cyc(2);

    // 1. run and count
    press_run();
    chk("t1_run", o_run, 1);
    cyc(10);
    chk("t1_first", count, 1);
    chk("t1_tick_hi", o_tick, 1);
    cyc(1);
    chk("t1_tick_lo", o_tick, 0);
    cyc(89);
    chk("t1_ten", count, 10);

    // stop and clear for a clean phase
    press_run();
    press_clear();
    cyc(2);
    chk("t1_cleared", count, 0);

    // 4. pause/resume keeps phase
    press_run();
    cyc(52);
    press_run();
    chk("t4_stopped", o_run, 0);
    chk("t4_count", count, 5);
    cyc(50);
    chk("t4_hold", count, 5);
    press_run();
    chk("t4_resumed", o_run, 1);
    cyc(6);
    chk("t4_before", count, 5);
    cyc(1);
    chk("t4_after", count, 6);
    chk("t4_tick", o_tick, 1);

    // 5. clear rules
    press_clear();
    chk("t5_clr_in_run", o_run, 1);
    wait_count(42, 500);
    press_run();
    chk("t5_stop_run", o_run, 0);
    chk("t5_stop_cnt", count, 42);
    cyc(3);
    press_clear();
    chk("t5_in_clear_cnt", count, 42);
    chk("t5_in_clear_run", o_run, 0);
    cyc(1);
    chk("t5_cleared", count, 0);
    chk("t5_cleared_run", o_run, 0);
    btn_run_stop = 1'b1; btn_clear = 1'b1;
    cyc(1);
    btn_run_stop = 1'b0; btn_clear = 1'b0;
    chk("t5_both_run", o_run, 0);
    cyc(12);
    chk("t5_both_run2", o_run, 0);
    chk("t5_both_cnt", count, 0);

    // 3. down mode
    sw_mode = 1'b1;
    press_run();
    cyc(10);
`ifdef STOPWATCH_COUNT_DOWN_EN
    chk("t3_first", count, 9999);
    cyc(10);
    chk("t3_second", count, 9998);
`else
    chk("t3_first", count, 1);
    cyc(10);
    chk("t3_second", count, 2);
`endif
    press_run();
    sw_mode = 1'b0;
    press_clear();
    cyc(2);

    // 6. reset mid-run with button held
    press_run();
    wait_count(17, 300);
    btn_run_stop = 1'b1; reset = 1'b1;
    cyc(1);
    chk("t6_rst_cnt", count, 0);
    chk("t6_rst_run", o_run, 0);
    cyc(2);
    reset = 1'b0;
    cyc(20);
    chk("t6_held_run", o_run, 0);
    chk("t6_held_cnt", count, 0);
    btn_run_stop = 1'b0;
    cyc(3);
    chk("t6_rel_run", o_run, 0);
    press_run();
    chk("t6_press_run", o_run, 1);
    cyc(10);
    chk("t6_count", count, 1);
    press_run();

    // 2. up wrap on the fast instance
    f_btn = 1'b1;
    cyc(1);
    f_btn = 1'b0;
    chk("t2_run", f_run, 1);
    n = 0;
    while (f_count != 14'd9999 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    chk("t2_max", f_count, 9999);
    chk("t2_max_tick", f_tick, 1);
    cyc(1);
    chk("t2_gap_tick", f_tick, 0);
    cyc(1);
    chk("t2_wrap", f_count, 0);
    chk("t2_wrap_tick", f_tick, 1);

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
